// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, default sizes and saturation limits for the MAC datapath
package mac_pkg;
  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W = 32;
  function automatic int sum_w(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: registered signed reduction of per-lane products into one lane sum
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int PW = 2 * DEF_DATA_W,
  parameter int SW = sum_w(DEF_DATA_W, DEF_NUM_LANES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_LANES*PW-1:0] prods,
  output logic signed [SW-1:0]    sum
);
  logic signed [SW-1:0] sum_c;
  // sign-extend every product to the sum width before adding so the total never overflows
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_LANES; i++) sum_c = sum_c + SW'($signed(prods[i*PW +: PW]));
  end
  // lane sum register, frozen together with the rest of the pipeline
  always_ff @(posedge clock or posedge reset)
    if (reset) sum <= '0;
    else if (en) sum <= sum_c;
endmodule

// File: rtl/mac_nbit_xn_acc.sv
// mac_nbit_xn_acc: multi-lane signed dot-product accumulator; MAC_ACC_SATURATE_EN selects saturating accumulation with osat
module mac_nbit_xn_acc
  import mac_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ivalid,
  output logic                          iready,
  input  logic                          ilast,
  input  logic [NUM_LANES*DATA_W-1:0]   dataa,
  input  logic [NUM_LANES*DATA_W-1:0]   datab,
  output logic                          ovalid,
  input  logic                          oready,
  output logic signed [ACC_W-1:0]       result
`ifdef MAC_ACC_SATURATE_EN
  , output logic                        osat
`endif
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = sum_w(DATA_W, NUM_LANES);
  if (ACC_W < SW || ACC_W > 64 || NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_cfg
    $error("mac_nbit_xn_acc: ACC_W must cover 2*DATA_W+clog2(NUM_LANES), be <= 64, and NUM_LANES must be 1..16");
  end
  logic                    en, v1, l1, v2, l2, first;
  logic [NUM_LANES*PW-1:0] prod_c, prod;
  logic signed [SW-1:0]    sum;
  logic signed [ACC_W-1:0] acc, ext, nxt;
  assign iready = !(ovalid && !oready);
  assign en = iready;
  assign ext = ACC_W'(sum);
  // per-lane full-precision signed products
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      prod_c[i*PW +: PW] = PW'($signed(dataa[i*DATA_W +: DATA_W])) * PW'($signed(datab[i*DATA_W +: DATA_W]));
  end
  // S1: product registers plus beat valid/last tags
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      prod <= '0;
    end else if (en) begin
      v1 <= ivalid;
      l1 <= ivalid && ilast;
      prod <= prod_c;
    end
  mac_adder_tree #(.NUM_LANES(NUM_LANES), .PW(PW), .SW(SW)) u_tree (
    .clock(clock),
    .reset(reset),
    .en(en),
    .prods(prod),
    .sum(sum)
  );
  // S2: tags travelling alongside the registered lane sum
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v2 <= 1'b0;
      l2 <= 1'b0;
    end else if (en) begin
      v2 <= v1;
      l2 <= l1;
    end
`ifdef MAC_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
  logic signed [ACC_W:0] wide;
  logic ovf, sat_acc, sat_nxt;
  // one guard bit exposes signed overflow; clamp toward the sign of the true sum
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
    ovf = wide[ACC_W] != wide[ACC_W-1];
    nxt = first ? ext : ovf ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];
    sat_nxt = !first && (sat_acc || ovf);
  end
  // sticky saturation flag for the burst and its copy presented with the result
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sat_acc <= 1'b0;
      osat <= 1'b0;
    end else if (en && v2) begin
      sat_acc <= sat_nxt;
      if (l2) osat <= sat_nxt;
    end
`else
  assign nxt = first ? ext : acc + ext;
`endif
  // S3: accumulate valid beats, publish the total on the closing beat
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      acc <= '0;
      result <= '0;
      ovalid <= 1'b0;
      first <= 1'b1;
    end else if (en) begin
      ovalid <= v2 && l2;
      if (v2) begin
        acc <= nxt;
        first <= l2;
        if (l2) result <= nxt;
      end
    end
endmodule

// File: tb/tb_mac_nbit_xn_acc.sv
// tb_mac_nbit_xn_acc: directed vectors with a queued scoreboard for mac_nbit_xn_acc
module tb_mac_nbit_xn_acc;
  localparam int NL = 2;
  localparam int DW = 8;
  localparam int AW = 18;
  logic clock = 1'b0, reset = 1'b1, ivalid = 1'b0, ilast = 1'b0, oready = 1'b1;
  logic iready, ovalid;
  logic [NL*DW-1:0] dataa = '0, datab = '0;
  logic signed [AW-1:0] result;
`ifdef MAC_ACC_SATURATE_EN
  logic osat;
`endif
  typedef struct {int res; bit sat; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, checks = 0, fails = 0;

  mac_nbit_xn_acc #(.NUM_LANES(NL), .DATA_W(DW), .ACC_W(AW)) dut (
    .clock(clock),
    .reset(reset),
    .ivalid(ivalid),
    .iready(iready),
    .ilast(ilast),
    .dataa(dataa),
    .datab(datab),
    .ovalid(ovalid),
    .oready(oready),
    .result(result)
`ifdef MAC_ACC_SATURATE_EN
    , .osat(osat)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock)
    if (!reset && ovalid) begin
      if (sb.size() == 0) chk("unexpected_ovalid", 1, 0);
      else if (oready) begin
        e = sb.pop_front();
        chk("result", result, e.res);
`ifdef MAC_ACC_SATURATE_EN
        chk("osat", osat, e.sat);
`endif
        if (e.due >= 0) chk("latency", cyc, e.due);
      end
    end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic beat(input int a0, input int a1, input int b0, input int b1, input bit last,
                      input int exp, input bit sat = 1'b0, input bit lat = 1'b1);
    int n = 0;
    ivalid = 1'b1;
    ilast = last;
    dataa = {DW'(a1), DW'(a0)};
    datab = {DW'(b1), DW'(b0)};
    while (!iready && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) chk("iready_timeout", 0, 1);
    if (last) sb.push_back('{exp, sat, lat ? cyc + 3 : -1});
    step(1);
    ivalid = 1'b0;
    ilast = 1'b0;
  endtask

  initial begin
    int n;
    step(2);
    chk("reset_ovalid", ovalid, 0);
    chk("reset_result", result, 0);
    reset = 1'b0;
    #1;
    chk("reset_iready", iready, 1);
    step(1);
    beat(3, -4, 5, 2, 1, 7);
    step(5);
    beat(127, 127, 127, 127, 0, 0);
    beat(127, 127, 127, 127, 0, 0);
    beat(127, 127, 127, 127, 0, 0);
    beat(127, 127, 127, 127, 1, 129032);
    beat(-128, -128, -128, -128, 1, 32768);
    step(5);
    oready = 1'b0;
    beat(3, -4, 5, 2, 1, 7, 1'b0, 1'b0);
    n = 0;
    while (!ovalid && n < 20) begin
      step(1);
      n++;
    end
    chk("stall_ovalid_seen", ovalid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ovalid", ovalid, 1);
      chk("stall_result", result, 7);
      chk("stall_iready", iready, 0);
      step(1);
    end
    oready = 1'b1;
    #1;
    chk("release_iready", iready, 1);
    step(1);
    chk("post_hs_ovalid", ovalid, 0);
    chk("post_hs_iready", iready, 1);
    step(2);
    for (int i = 0; i < 4; i++) beat(-128, -128, -128, -128, 0, 0);
`ifdef MAC_ACC_SATURATE_EN
    beat(-128, -128, -128, -128, 1, 131071, 1'b1);
`else
    beat(-128, -128, -128, -128, 1, -98304);
`endif
    step(5);
    beat(1, 1, 1, 1, 0, 0);
    beat(1, 1, 1, 1, 0, 0);
    reset = 1'b1;
    step(1);
    chk("midreset_ovalid", ovalid, 0);
    reset = 1'b0;
    step(1);
    beat(1, 1, 1, 1, 1, 2);
    step(5);
    beat(1, 2, 3, 4, 0, 0);
    step(2);
    beat(1, 2, 3, 4, 0, 0);
    step(2);
    beat(1, 2, 3, 4, 1, 33);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step(1);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mac_nbit_xn_acc.md
MAC_NBIT_XN_ACC -- requirements
Module: mac_nbit_xn_acc

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2: number of parallel multiplier lanes (1..16).
REQ-002 SHALL have parameter DATA_W, default 8: signed operand width per lane.
REQ-003 SHALL have parameter ACC_W, default 32: accumulator/result width; SHALL be at least 2*DATA_W+clog2(NUM_LANES), checked at elaboration.
REQ-004 SHALL have ports: clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ivalid  input  1  input beat valid.
REQ-007 iready  output  1  block can accept a beat this cycle.
REQ-008 ilast  input  1  beat closes the current accumulation burst.
REQ-009 dataa  input  NUM_LANES*DATA_W  signed operands; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 datab  input  NUM_LANES*DATA_W  signed operands, same packing.
REQ-011 ovalid  output  1  result valid.
REQ-012 oready  input  1  downstream accepts result.
REQ-013 result  output  ACC_W  signed accumulated dot product of one burst.

Function
REQ-014 Beat accepted when ivalid && iready; iready = !(ovalid && !oready).
REQ-015 Three-stage pipeline, all stages share one enable equal to iready: S1 registers per-lane signed products; S2 registers signed lane sum (width 2*DATA_W+clog2(NUM_LANES)); S3 registers accumulator and output.
REQ-016 S3: if first beat of burst, acc = sign-extended sum; else acc = acc + sign-extended sum; arithmetic wraps modulo 2^ACC_W.
REQ-017 First-of-burst flag set at reset and after every beat carrying ilast; cleared by any other beat.
REQ-018 Beat carrying ilast accepted at cycle t, no stalls: ovalid=1 and result valid at t+3.
REQ-019 ovalid asserts only for ilast beats; result holds the final accumulated value until handshake.
REQ-020 ovalid && !oready: entire pipeline frozen, result and ovalid stable, no beat accepted.
REQ-021 ovalid && oready with no new ilast beat reaching S3: ovalid deasserts next cycle.
REQ-022 ivalid=0 cycles are bubbles: per-stage valid bits propagate, accumulator unchanged by bubbles.
REQ-023 Burst of one beat (ilast on first beat) SHALL yield that beat's lane sum.
REQ-024 Back-to-back bursts SHALL be supported without idle cycles; throughput one beat per cycle while oready=1.

Reset
REQ-025 Reset clears all stage valid bits, ovalid=0, result=0, accumulator=0, first-of-burst flag=1; iready=1 when reset deasserted.
REQ-026 Reset mid-burst discards the partial burst; no result produced for it.

Configuration
REQ-027 Macro MAC_ACC_SATURATE_EN defined: accumulator add saturates to signed ACC_W max/min instead of wrapping, and extra output port osat (output, 1) flags that the presented result saturated at any beat of its burst; sticky per burst, cleared on first beat, 0 after reset.
REQ-028 Macro undefined: wrap behaviour of REQ-016, no osat port.

Structure
REQ-029 Package mac_pkg SHALL hold the sum-width function, default DATA_W/ACC_W/NUM_LANES constants, and the saturation limit functions.
REQ-030 One sub-module mac_adder_tree (registered-output signed reduction of NUM_LANES products, forming S2) SHALL be used.

Verification
REQ-031 NUM_LANES=2, DATA_W=8: single beat a=(3,-4), b=(5,2), ilast=1 -> result 7, ovalid exactly 3 cycles after accept.
REQ-032 Burst of 4 beats, all operands 127, ilast on beat 4 -> result 129032; then immediate next burst a=(-128,-128), b=(-128,-128) single beat -> 32768 on following cycle.
REQ-033 Hold oready=0 when result pending -> ovalid, result stable, iready=0 for 5 cycles; raise oready -> handshake, iready=1 next cycle.
REQ-034 ACC_W=18, 5 beats a=b=(-128,-128): macro defined -> result 131071, osat=1; undefined -> result -98304.
REQ-035 Accept 2 beats, assert reset 1 cycle, then single beat a=(1,1), b=(1,1), ilast=1 -> result 2, no earlier ovalid.
REQ-036 Burst of 3 beats a=(1,2),b=(3,4) with 2-cycle ivalid gaps between beats -> result 33.
